// File: rtl/dma_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_reg_file_if
// Purpose  : CPU register bus and channel transfer signals of the DMA register file.
// Revision : 1.0 - initial release
// ============================================================================
interface dma_reg_file_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16
);
    logic              REG_WR;
    logic              REG_RD;
    logic [4:0]        REG_ADDR;
    logic [7:0]        DIN;
    logic [7:0]        DOUT;
    logic              XFER_STEP;
    logic [2:0]        CH_SEL;
    logic [ADDR_W-1:0] CUR_ADDR;
    logic [5:0]        CUR_MODE;
    logic [NUM_CH-1:0] MASK;
    logic [NUM_CH-1:0] REQ;
    logic [7:0]        COMMAND;
    logic              TC;

    modport master (
        output REG_WR, REG_RD, REG_ADDR, DIN, XFER_STEP, CH_SEL,
        input  DOUT, CUR_ADDR, CUR_MODE, MASK, REQ, COMMAND, TC
    );

    modport slave (
        input  REG_WR, REG_RD, REG_ADDR, DIN, XFER_STEP, CH_SEL,
        output DOUT, CUR_ADDR, CUR_MODE, MASK, REQ, COMMAND, TC
    );
endinterface
`default_nettype wire

// File: rtl/dma_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : dma_reg_file
// Purpose  : 8237-style DMA channel register file. Optional macro
//            DMA_AUTOINIT_EN enables base-to-current reload on terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module dma_reg_file #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int COUNT_W = 16
) (
    input wire             CLK,
    input wire             RESET,
    dma_reg_file_if.slave  bus
);
    localparam logic [4:0] c_idx_cmd  = 5'd16;
    localparam logic [4:0] c_idx_req  = 5'd17;
    localparam logic [4:0] c_idx_smsk = 5'd18;
    localparam logic [4:0] c_idx_cptr = 5'd19;
    localparam logic [4:0] c_idx_mclr = 5'd20;
    localparam logic [4:0] c_idx_cmsk = 5'd21;
    localparam logic [4:0] c_idx_wmsk = 5'd22;

    logic [ADDR_W-1:0]  r_base_addr [NUM_CH];
    logic [ADDR_W-1:0]  r_cur_addr  [NUM_CH];
    logic [COUNT_W-1:0] r_base_cnt  [NUM_CH];
    logic [COUNT_W-1:0] r_cur_cnt   [NUM_CH];
    logic [5:0]         r_mode      [NUM_CH];
    logic [7:0]         r_command, r_temp, r_dout;
    logic [NUM_CH-1:0]  r_mask, r_req, r_status;
    logic               r_ptr, r_tc;

    logic               w_wr, w_rd, w_st_rd;
    logic [NUM_CH-1:0]  w_step, w_tc_hit, w_auto;
    logic [15:0]        w_word;
    logic [7:0]         w_rdata;

    // Replace one byte of a zero-extended register image
    function automatic logic [15:0] f_set_byte(input logic [15:0] v, input logic hi,
                                               input logic [7:0] d);
        logic [15:0] r;
        r = v;
        if (hi) r[15:8] = d;
        else    r[7:0]  = d;
        return r;
    endfunction

    assign w_wr    = bus.REG_WR;
    assign w_rd    = bus.REG_RD & ~bus.REG_WR;
    assign w_st_rd = w_rd && (bus.REG_ADDR == c_idx_cmd);

    always_comb begin
        w_step   = '0;
        w_tc_hit = '0;
        w_auto   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_step[ch]   = bus.XFER_STEP && (bus.CH_SEL == 3'(ch));
            w_tc_hit[ch] = w_step[ch] && (r_cur_cnt[ch] == '0);
`ifdef DMA_AUTOINIT_EN
            w_auto[ch]   = r_mode[ch][2];
`endif
        end
    end

    always_comb begin
        w_rdata = '0;
        w_word  = '0;
        if (!bus.REG_ADDR[4]) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (bus.REG_ADDR[3:1] == 3'(ch)) begin
                    w_word  = bus.REG_ADDR[0] ? 16'(r_cur_cnt[ch]) : 16'(r_cur_addr[ch]);
                    w_rdata = r_ptr ? w_word[15:8] : w_word[7:0];
                end
            end
        end else begin
            case (bus.REG_ADDR)
                c_idx_cmd:  w_rdata = 8'(r_status);
                c_idx_req:  w_rdata = 8'(r_req);
                c_idx_mclr: w_rdata = r_temp;
                default: begin
                    for (int ch = 0; ch < NUM_CH; ch++)
                        if (bus.REG_ADDR == 5'(24 + ch)) w_rdata = {2'b00, r_mode[ch]};
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_base_addr[ch] <= '0;
                r_cur_addr[ch]  <= '0;
                r_base_cnt[ch]  <= '0;
                r_cur_cnt[ch]   <= '0;
                r_mode[ch]      <= '0;
            end
            r_command <= '0;
            r_temp    <= '0;
            r_dout    <= '0;
            r_mask    <= '1;
            r_req     <= '0;
            r_status  <= '0;
            r_ptr     <= 1'b0;
            r_tc      <= 1'b0;
        end else if (w_wr && (bus.REG_ADDR == c_idx_mclr)) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_base_addr[ch] <= '0;
                r_cur_addr[ch]  <= '0;
                r_base_cnt[ch]  <= '0;
                r_cur_cnt[ch]   <= '0;
                r_mode[ch]      <= '0;
            end
            r_command <= '0;
            r_temp    <= '0;
            r_dout    <= '0;
            r_mask    <= '1;
            r_req     <= '0;
            r_status  <= '0;
            r_ptr     <= 1'b0;
            r_tc      <= 1'b0;
        end else begin
            r_tc     <= |w_tc_hit;
            // A flag raised on the same edge as a status read survives the clear
            r_status <= (w_st_rd ? '0 : r_status) | w_tc_hit;
            if (w_rd) r_dout <= w_rdata;
            if ((w_wr || w_rd) && !bus.REG_ADDR[4]) r_ptr <= ~r_ptr;
            if (w_wr && (bus.REG_ADDR == c_idx_cptr)) r_ptr <= 1'b0;

            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_step[ch]) begin
                    if (w_tc_hit[ch] && w_auto[ch]) begin
                        r_cur_addr[ch] <= r_base_addr[ch];
                        r_cur_cnt[ch]  <= r_base_cnt[ch];
                    end else begin
                        r_cur_addr[ch] <= r_mode[ch][3] ? r_cur_addr[ch] - ADDR_W'(1)
                                                        : r_cur_addr[ch] + ADDR_W'(1);
                        r_cur_cnt[ch]  <= r_cur_cnt[ch] - COUNT_W'(1);
                    end
                    if (w_tc_hit[ch] && !w_auto[ch]) begin
                        r_mask[ch] <= 1'b1;
                        r_req[ch]  <= 1'b0;
                    end
                end
            end

            // CPU writes come last so they override a coincident step
            if (w_wr) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (!bus.REG_ADDR[4] && (bus.REG_ADDR[3:1] == 3'(ch))) begin
                        if (!bus.REG_ADDR[0]) begin
                            r_base_addr[ch] <= ADDR_W'(f_set_byte(16'(r_base_addr[ch]), r_ptr, bus.DIN));
                            r_cur_addr[ch]  <= ADDR_W'(f_set_byte(16'(r_cur_addr[ch]), r_ptr, bus.DIN));
                        end else begin
                            r_base_cnt[ch]  <= COUNT_W'(f_set_byte(16'(r_base_cnt[ch]), r_ptr, bus.DIN));
                            r_cur_cnt[ch]   <= COUNT_W'(f_set_byte(16'(r_cur_cnt[ch]), r_ptr, bus.DIN));
                        end
                    end
                    if (bus.REG_ADDR == 5'(24 + ch)) r_mode[ch] <= bus.DIN[5:0];
                    if (bus.DIN[2:0] == 3'(ch)) begin
                        if (bus.REG_ADDR == c_idx_req)  r_req[ch]  <= bus.DIN[3];
                        if (bus.REG_ADDR == c_idx_smsk) r_mask[ch] <= bus.DIN[3];
                    end
                end
                if (bus.REG_ADDR == c_idx_cmd)  r_command <= bus.DIN;
                if (bus.REG_ADDR == c_idx_cmsk) r_mask    <= '0;
                if (bus.REG_ADDR == c_idx_wmsk) r_mask    <= bus.DIN[NUM_CH-1:0];
            end
        end
    end

    always_comb begin
        bus.CUR_ADDR = '0;
        bus.CUR_MODE = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (bus.CH_SEL == 3'(ch)) begin
                bus.CUR_ADDR = r_cur_addr[ch];
                bus.CUR_MODE = r_mode[ch];
            end
        end
    end

    assign bus.DOUT    = r_dout;
    assign bus.MASK    = r_mask;
    assign bus.REQ     = r_req;
    assign bus.COMMAND = r_command;
    assign bus.TC      = r_tc;
endmodule
`default_nettype wire

// File: doc/dma_reg_file.md
DMA_REG_FILE -- requirements
Module: dma_reg_file

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (legal 1..8).
REQ-002 SHALL have parameter ADDR_W, default 16, current/base address width (legal 9..16).
REQ-003 SHALL have parameter COUNT_W, default 16, current/base word-count width (legal 9..16).
REQ-004 SHALL have port CLK  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports REG_WR  in  1  and  REG_RD  in  1, single-cycle CPU write/read strobes (both high same cycle: write only).
REQ-007 SHALL have port REG_ADDR  in  5  register index.
REQ-008 SHALL have ports DIN  in  8  CPU write data and  DOUT  out  8  registered read data.
REQ-009 SHALL have ports XFER_STEP  in  1  one-cycle transfer-done pulse and  CH_SEL  in  3  channel it applies to.
REQ-010 SHALL have outputs CUR_ADDR  ADDR_W  and  CUR_MODE  6  for channel CH_SEL (combinational).
REQ-011 SHALL have outputs MASK  NUM_CH,  REQ  NUM_CH,  COMMAND  8, and  TC  1 (registered pulse).

Function
REQ-012 Index map SHALL be: 2ch = address, 2ch+1 = word count (ch<NUM_CH); 16 command(W)/status(R); 17 request(W)/request vector(R); 18 single mask; 19 clear byte pointer; 20 master clear(W)/temp(R); 21 clear all masks; 22 write all masks; 24+ch mode; others read 0, write ignored.
REQ-013 Indices 0..15 SHALL use one shared byte pointer: 0 = low byte, 1 = high byte (bits above width ignored/read 0); every access to 0..15 toggles it.
REQ-014 Address/count write SHALL load the addressed byte into both base and current registers.
REQ-015 Address/count read SHALL return the current-register byte selected by the pointer.
REQ-016 DOUT SHALL update exactly one cycle after REG_RD; hold its value otherwise.
REQ-017 Writes 17/18 SHALL use DIN[2:0] = channel, DIN[3] = 1 set / 0 clear; channel >= NUM_CH ignored.
REQ-018 Write 22 SHALL load MASK from DIN[NUM_CH-1:0]; write 21 clears MASK.
REQ-019 Mode register SHALL hold DIN[5:0]: [1:0] type, [2] autoinit, [3] decrement, [5:4] transfer mode.
REQ-020 Status read SHALL return TC flags in bits [NUM_CH-1:0], upper bits 0, and clear those flags the same edge.
REQ-021 On XFER_STEP with CH_SEL<NUM_CH: current address +1 (mode[3]=0) or -1 (mode[3]=1), modulo 2^ADDR_W; current count -1 modulo 2^COUNT_W.
REQ-022 Terminal count SHALL be the step where current count is 0 before decrement: TC pulses 1 cycle later, status TC bit sets.
REQ-023 On terminal count without autoinit SHALL set that channel's MASK bit and clear its REQ bit.
REQ-024 XFER_STEP with CH_SEL>=NUM_CH SHALL be ignored.
REQ-025 CPU write to a channel's current register coincident with XFER_STEP on that channel: CPU write SHALL win.
REQ-026 TC set coincident with status read: flag SHALL remain set (set wins).
REQ-027 Master clear (write 20) SHALL act as reset except MASK becomes all-ones.

Reset
REQ-028 RESET low SHALL immediately clear all base/current/mode registers, COMMAND, REQ, status, temp, byte pointer, DOUT, TC.
REQ-029 RESET low SHALL set MASK to all-ones; mid-transfer reset SHALL abort with no TC pulse.

Configuration
REQ-030 Macro DMA_AUTOINIT_EN defined: terminal count on a channel with mode[2]=1 SHALL reload current address/count from base in the same edge, MASK unchanged, TC still pulses.
REQ-031 Macro DMA_AUTOINIT_EN undefined: mode[2] SHALL be stored and read back but ignored; REQ-023 applies to all channels.

Verification
REQ-032 Reset, then read index 22 region: MASK=4'hF, DOUT=8'h00 for status read, TC=0.
REQ-033 Write idx0 8'h34 then 8'h12, write idx1 8'h02 then 8'h00; three XFER_STEP ch0 -> CUR_ADDR 16'h1237, count 16'hFFFF, TC pulse on third step, MASK[0]=1.
REQ-034 Mode ch1 = 6'b001000 (decrement), address 16'h0000, one step -> CUR_ADDR 16'hFFFF.
REQ-035 DMA_AUTOINIT_EN defined, ch2 mode[2]=1, address 16'h0100, count 0, one step -> current reloaded to 16'h0100/0, MASK[2]=0, status bit2=1, second status read returns 0.
REQ-036 Status read same cycle as TC on ch3 -> DOUT bit3 reflects prior value, status bit3=1 afterwards.
REQ-037 Assert RESET low mid-sequence with count 1 -> all registers zero, MASK all-ones, no TC pulse.
